// File: rtl/mem2reg_stream_reader_if.sv
// Bundle for mem2reg_stream_reader: random-access write port, stream start
// command and the valid/ready output stream.
//   master : the side issuing writes/starts and consuming the stream
//   slave  : the reader block itself
interface mem2reg_stream_reader_if #(
   parameter int AW    = 3,
   parameter int WIDTH = 4
);
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             start;
   logic [AW-1:0]    start_addr;
   logic [AW:0]      count;
   logic             busy;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [AW-1:0]    out_addr;
   logic             out_last;
   logic             done;

   modport master (
      output wr_en, wr_addr, wr_data, start, start_addr, count, out_ready,
      input  busy, out_valid, out_data, out_addr, out_last, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start, start_addr, count, out_ready,
      output busy, out_valid, out_data, out_addr, out_last, done
   );
endinterface

// File: rtl/mem2reg_stream_reader.sv
// Register-array memory (discrete flops, one per entry) with a write port
// and a streaming read engine. A start in IDLE streams `count` entries from
// `start_addr` upward, wrapping at the top, over a valid/ready handshake.
// Ports:
//   clk_i    : clock, rising edge
//   reset_i  : asynchronous, active-high reset
//   bus_io   : slave side of mem2reg_stream_reader_if (write port, start
//              command, out_valid/out_ready stream, busy, done pulse)
module mem2reg_stream_reader #(
   parameter int AW    = 3,
   parameter int WIDTH = 4
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   mem2reg_stream_reader_if.slave  bus_io
);
   localparam int DEPTH = 2**AW;
   localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0] CNT_TWO = (AW+1)'(2);

   typedef enum logic {IDLE, SEND} state_e;

   state_e           state_q, state_d;
   logic [AW:0]      rem_q, rem_d;
   logic [AW-1:0]    out_addr_q, out_addr_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic             done_q, done_d;

   logic             load_en;
   logic [AW-1:0]    load_addr;
   logic [WIDTH-1:0] load_val;

   logic [WIDTH-1:0] mem_q [DEPTH];

   // One register per entry; reset value is the entry index.
   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      always_ff @(posedge clk_i or posedge reset_i) begin
         if (reset_i)
            mem_q[g] <= WIDTH'(g);
         else if (bus_io.wr_en && bus_io.wr_addr == AW'(g))
            mem_q[g] <= bus_io.wr_data;
      end
   end

   // Write-first: a same-cycle write to the entry being captured wins.
   assign load_val = (bus_io.wr_en && bus_io.wr_addr == load_addr) ?
                     bus_io.wr_data : mem_q[load_addr];

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      out_addr_d  = out_addr_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      load_en     = 1'b0;
      load_addr   = out_addr_q;
      case (state_q)
         IDLE: begin
            if (bus_io.start) begin
               if (bus_io.count != '0) begin
                  state_d     = SEND;
                  load_en     = 1'b1;
                  load_addr   = bus_io.start_addr;
                  out_addr_d  = bus_io.start_addr;
                  rem_d       = bus_io.count;
                  out_valid_d = 1'b1;
                  out_last_d  = (bus_io.count == CNT_ONE);
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         SEND: begin
            // out_valid is always high here, so a transfer is just out_ready.
            if (bus_io.out_ready) begin
               if (rem_q > CNT_ONE) begin
                  load_en    = 1'b1;
                  load_addr  = out_addr_q + AW'(1);
                  out_addr_d = load_addr;
                  rem_d      = rem_q - CNT_ONE;
                  out_last_d = (rem_q == CNT_TWO);
               end else begin
                  state_d     = IDLE;
                  rem_d       = '0;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  done_d      = 1'b1;
               end
            end
         end
      endcase
      out_data_d = load_en ? load_val : out_data_q;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
      end
   end

   assign bus_io.busy      = out_valid_q;
   assign bus_io.out_valid = out_valid_q;
   assign bus_io.out_data  = out_data_q;
   assign bus_io.out_addr  = out_addr_q;
   assign bus_io.out_last  = out_last_q;
   assign bus_io.done      = done_q;
endmodule

// File: doc/mem2reg_stream_reader.md
# mem2reg_stream_reader

Register-array memory with a random-access write port and a sequential streaming read engine. The array is built as discrete registers (mem2reg style), not as an inferred RAM. On a start command it reads `count` consecutive entries from `start_addr` onward, wrapping at the top, and presents each one on a valid/ready output handshake. It is the reader counterpart to the array-writer blocks and drains snapshots of register arrays into downstream logic.

## Interface

Parameters:
- `AW`, 3, address width; depth is `2**AW`.
- `WIDTH`, 4, data width per entry.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  reset, asynchronous and active-high.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  AW  write address.
- `wr_data`  in  WIDTH  write data.
- `start`  in  1  stream request; sampled only in IDLE.
- `start_addr`  in  AW  first entry to stream.
- `count`  in  AW+1  number of entries to stream, 0 to `2**(AW+1)-1`.
- `busy`  out  1  high while in SEND.
- `out_valid`  out  1  output entry valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  WIDTH  entry value, registered.
- `out_addr`  out  AW  address of presented entry.
- `out_last`  out  1  presented entry is the final one of the stream.
- `done`  out  1  one-cycle pulse after stream completion.

## Operation

- **Reset:** entry i = i truncated to WIDTH. State goes to IDLE. `busy`, `out_valid`, `out_last`, `done` = 0. `out_data` and `out_addr` = 0. Internal remaining counter = 0.
- **Write port:** when `wr_en` is high, entry `wr_addr` takes `wr_data` at the edge. This holds in every state and also during streaming.
- **States:** IDLE and SEND.
  - IDLE with `start` and `count`≠0: go to SEND. Load `out_addr`=`start_addr` and `out_data`=entry[`start_addr`]. Set remaining=`count`, `out_valid`=1, and `out_last`=(`count`==1).
  - IDLE with `start` and `count`=0: stay in IDLE and pulse `done` the next cycle. No data is emitted.
  - SEND: a transfer occurs on a cycle where `out_valid`&&`out_ready`.
    - Transfer with remaining>1: advance `out_addr` by 1 modulo `2**AW`, load `out_data` from the new address, decrement remaining, and set `out_last`=(remaining after decrement ==1).
    - Transfer with remaining==1: go to IDLE. Clear `out_valid` and `out_last`, and pulse `done`.
- **Held output:** while `out_valid`&&!`out_ready`, `out_data`, `out_addr` and `out_last` hold stable. A write to the presented address does not change the presented `out_data`; each entry is captured once, when it is presented.
- **Load bypass:** if `wr_en` is high and `wr_addr` equals the address being loaded into `out_data` in the same cycle, the loaded value is `wr_data` (write-first).
- **Wrap:** with `count` > `2**AW` the stream wraps and re-reads entries, each re-read returning current array contents.
- **Ignored start:** `start` is ignored while in SEND.
- **Start on done:** `start` in the same cycle that `done` is high is accepted, because the state is already IDLE.
- **Reset mid-stream:** outputs drop immediately (asynchronous), the array is re-initialised, and no `done` is produced.

## Timing

- Start accepted at edge N gives `out_valid`=1 and the first entry visible after edge N.
- With `out_ready` held high, one entry transfers per cycle, so the stream of `count` entries occupies `count` consecutive cycles.
- The last transfer at edge M is followed by `out_valid`=0, `busy`=0 and `done`=1 after edge M. `done` is low again after edge M+1.
- `count`=0: `done`=1 for one cycle after the accepting edge.
- `busy` is equal to `out_valid`.
- No combinational path from `out_ready` to any output.

## Test plan

- **Reset readout:** after reset, start with `start_addr`=0, `count`=8, `out_ready`=1 → `out_data` is 0,1,…,7 on 8 consecutive cycles; `out_last` is high only with 7; `done` pulses the following cycle.
- **Write then wrapped read:** write entry 6=4'hA and entry 1=4'h5, then start with `start_addr`=6, `count`=4 → `out_addr` is 6,7,0,1 and `out_data` is A,7,0,5.
- **Backpressure:** start with `start_addr`=2, `count`=3; hold `out_ready`=0 for 3 cycles → `out_data`=2 and `out_addr`=2 stay stable. Then toggle `out_ready` 1,0,1,1 → exactly 3 transfers (2,3,4), followed by a single `done`.
- **Write hazards:** while entry 3 is presented and stalled, write entry 3=4'hF → `out_data` stays 3. In the cycle that entry 4 is loaded, write entry 4=4'hC → `out_data` becomes C.
- **Count edge cases:** `count`=0 → no `out_valid`, `done` after 1 cycle. `count`=10 from `start_addr`=0 → addresses 0…7,0,1. `start` pulsed during SEND has no effect. `start` during the `done` cycle starts a new stream.
- **Reset mid-stream:** assert `reset` mid-stream → `out_valid`, `busy` and `done` go to 0 immediately. After release, a `count`=8 readout returns 0…7.
